paged_pmem_fetch: RTL and testbench
===================================

// Module: paged_pmem_fetch
// PURPOSE
//  Synthesisable paged program memory and fetch unit for the 8bit-simple core.
//  Holds NUM_PAGES pages of 2**PC_LEN instructions. A loader fills them over a
//  valid/ready port while the core is held in reset. The unit then releases the core and
//  drives INSTR from pages[page_cur][PC]. Page switches are requested by the core and
//  take effect on the next fetch at PC==0. The unit sits between the loader/host and the core.
// PARAMETERS
//  PC_LEN     `PC_LEN     program counter width; words per page = 2**PC_LEN
//  INSTR_LEN  `INSTR_LEN  instruction width
//  NUM_PAGES  128         number of pages, >=2; need not be a power of two
//  NOP_INSTR  '0          value driven on INSTR while the core is held in reset
// PORTS
//  CLK        in   1          clock
//  RSTN       in   1          async active-low reset
//  ld_valid   in   1          loader word valid
//  ld_ready   out  1          unit accepts the loader word
//  ld_page    in   PAGE_W     target page, PAGE_W = $clog2(NUM_PAGES)
//  ld_addr    in   PC_LEN     word offset within the page
//  ld_data    in   INSTR_LEN  instruction word
//  ld_last    in   1          final word of the image; qualified by the handshake
//  reload     in   1          one-cycle pulse: return to LOAD from RUN
//  pg_valid   in   1          core page-switch request strobe
//  pg_page    in   PAGE_W     requested page
//  PC         in   PC_LEN     core program counter
//  INSTR      out  INSTR_LEN  fetched instruction
//  core_rstn  out  1          active-low reset to the core
//  page_cur   out  PAGE_W     page currently being fetched
//  pg_pending out  1          a page switch is latched and not yet applied
//  pg_err     out  1          sticky flag: out-of-range page requested
// BEHAVIOUR
//  Reset values: state=LOAD, ld_ready=1, INSTR=NOP_INSTR, core_rstn=0, page_cur=0,
//   pg_pending=0, pg_err=0. Memory contents are not reset.
//  FSM LOAD:
//   - ld_ready=1. A word is written when ld_valid&&ld_ready.
//   - If ld_page>=NUM_PAGES, the write is dropped and pg_err is set.
//   - A handshake with ld_last=1 moves to RUN on the next edge.
//  FSM RUN:
//   - ld_ready=0. core_rstn=1 from the first RUN cycle.
//   - reload=1 returns to LOAD: core_rstn=0 and INSTR=NOP_INSTR on the same edge;
//     page_cur=0; pending cleared; pg_err kept.
//  Fetch in RUN: on each posedge, INSTR <= mem[page_cur][PC]. Latency is 1 cycle from PC.
//  Page switch:
//   - pg_valid with pg_page<NUM_PAGES latches pend_page and sets pg_pending.
//   - A later request overwrites the earlier one (last wins).
//   - pg_page>=NUM_PAGES sets pg_err; the pending state is unchanged.
//   - The switch is applied on the first edge with PC==0 and pg_pending=1. On that edge,
//     the fetch uses pend_page, page_cur<=pend_page and pg_pending<=0.
//   - If pg_valid and PC==0 occur on the same edge, the new request is latched only.
//     It applies at the next PC==0, never on the same edge.
//  pg_valid and reload are ignored in LOAD. reload has priority over all other RUN events.
//  PC wrap from 2**PC_LEN-1 to 0 is an ordinary PC==0 event.
//  Async reset mid-load or mid-run aborts immediately to the reset values.
// CONFIGURATION
//  PMEM_NEGEDGE_FETCH_EN defined:
//   - the INSTR register updates on negedge CLK, half a cycle after PC changes;
//   - the page-switch apply is evaluated at the same negedge;
//   - all other state stays on posedge.
//  PMEM_NEGEDGE_FETCH_EN undefined: all logic is on posedge, with 1-cycle fetch latency.
// STRUCTURE
//  Package pmem_pkg: PAGE_W, typedef page_t, typedef instr_t, enum pmem_state_e {LOAD,RUN}.
//  Sub-module pmem_array: single-port-write / async-read RAM, NUM_PAGES*2**PC_LEN words.
//   Its index is page*2**PC_LEN + offset.
//  Top level contains the FSM, page-switch logic and INSTR register.
// TESTING
//  1. Load page0[0..3]=8'h11..8'h14, ld_last on the 4th word; PC=0,1 ->
//     core_rstn rises; INSTR=8'h11, then 8'h12 one cycle later (half a cycle with the macro).
//  2. pg_valid page=5 at PC=7 -> pg_pending=1 and page_cur=0 until PC=0;
//     then INSTR=page5[0] and page_cur=5.
//  3. pg_valid page=3 then page=6 before PC=0 -> page_cur=6. Same-edge pg_valid+PC==0 -> deferred.
//  4. pg_page=NUM_PAGES, and ld_page=NUM_PAGES in LOAD -> pg_err=1 (sticky); page and memory unchanged.
//  5. reload mid-run -> core_rstn=0, INSTR=NOP_INSTR, ld_ready=1, page_cur=0.
//     A reload with new words gives new INSTR values.
//  6. RSTN low mid-load -> all outputs at reset values; the reloaded image then runs correctly.

Source files
------------

// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and defaults for the paged program memory
`ifndef PC_LEN
`define PC_LEN 8
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 8
`endif

package pmem_pkg;

  // Widths for the default build of 128 pages
  localparam int PAGE_W = $clog2(128);

  typedef logic [PAGE_W-1:0]     page_t;
  typedef logic [`INSTR_LEN-1:0] instr_t;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } pmem_state_e;

endpackage

// File: rtl/paged_pmem_fetch_if.sv
// rtl/paged_pmem_fetch_if.sv - loader, core and status signals of the paged fetch unit
interface paged_pmem_fetch_if #(
  parameter int PC_LEN    = 8,
  parameter int INSTR_LEN = 8,
  parameter int PAGE_W    = 7
);
  logic                 ld_valid;
  logic                 ld_ready;
  logic [PAGE_W-1:0]    ld_page;
  logic [PC_LEN-1:0]    ld_addr;
  logic [INSTR_LEN-1:0] ld_data;
  logic                 ld_last;
  logic                 reload;
  logic                 pg_valid;
  logic [PAGE_W-1:0]    pg_page;
  logic [PC_LEN-1:0]    PC;
  logic [INSTR_LEN-1:0] INSTR;
  logic                 core_rstn;
  logic [PAGE_W-1:0]    page_cur;
  logic                 pg_pending;
  logic                 pg_err;

  modport slave (
    input  ld_valid, ld_page, ld_addr, ld_data, ld_last, reload, pg_valid, pg_page, PC,
    output ld_ready, INSTR, core_rstn, page_cur, pg_pending, pg_err
  );

  modport master (
    output ld_valid, ld_page, ld_addr, ld_data, ld_last, reload, pg_valid, pg_page, PC,
    input  ld_ready, INSTR, core_rstn, page_cur, pg_pending, pg_err
  );
endinterface

// File: rtl/pmem_array.sv
// rtl/pmem_array.sv - single write port, asynchronous read instruction RAM (not reset)
module pmem_array #(
  parameter int AW    = 15,
  parameter int DEPTH = 32768,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Loader write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/paged_pmem_fetch.sv
// rtl/paged_pmem_fetch.sv - paged program memory, loader FSM and fetch unit; PMEM_NEGEDGE_FETCH_EN moves fetch to negedge
module paged_pmem_fetch
  import pmem_pkg::*;
#(
  parameter int                   PC_LEN    = `PC_LEN,
  parameter int                   INSTR_LEN = `INSTR_LEN,
  parameter int                   NUM_PAGES = 128,
  parameter logic [INSTR_LEN-1:0] NOP_INSTR = '0
) (
  input logic               CLK,
  input logic               RSTN,
  paged_pmem_fetch_if.slave bus
);
  localparam int PAGE_W = $clog2(NUM_PAGES);
  localparam int AW     = PAGE_W + PC_LEN;
  localparam int DEPTH  = NUM_PAGES << PC_LEN;
  localparam logic [PAGE_W:0] PAGE_LIMIT = (PAGE_W + 1)'(NUM_PAGES);

  pmem_state_e          state_q, state_d;
  logic                 run, ld_fire, ld_ok, pg_ok, req, apply, pending, pg_err_q;
  logic [PAGE_W-1:0]    page_cur_q, pend_page_q, fetch_page;
  logic [INSTR_LEN-1:0] rdata, instr_q;

  assign run     = (state_q == RUN);
  assign ld_fire = !run && bus.ld_valid;
  assign ld_ok   = {1'b0, bus.ld_page} < PAGE_LIMIT;
  assign pg_ok   = {1'b0, bus.pg_page} < PAGE_LIMIT;
  // reload wins over any page request on the same edge
  assign req     = run && !bus.reload && bus.pg_valid;

  pmem_array #(.AW(AW), .DEPTH(DEPTH), .DW(INSTR_LEN)) u_array (
    .clk   (CLK),
    .we    (ld_fire && ld_ok),
    .waddr ({bus.ld_page, bus.ld_addr}),
    .wdata (bus.ld_data),
    .raddr ({fetch_page, bus.PC}),
    .rdata (rdata)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // Next state: last loader word starts the core, reload returns to loading
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (ld_fire && bus.ld_last) state_d = RUN;
      RUN:     if (bus.reload) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Sticky out-of-range flag from either the loader or the core
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                     pg_err_q <= 1'b0;
    else if ((ld_fire && !ld_ok) || (req && !pg_ok)) pg_err_q <= 1'b1;
  end

`ifdef PMEM_NEGEDGE_FETCH_EN
  // Requests are latched on posedge and applied on negedge; a toggle pair
  // keeps each register owned by a single edge.
  logic req_tog_q, ack_tog_q;

  assign pending    = run && (req_tog_q != ack_tog_q);
  assign apply      = pending && (bus.PC == '0);
  assign fetch_page = apply ? pend_page_q : page_cur_q;

  // Latch the most recent valid page request
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      req_tog_q   <= 1'b0;
      pend_page_q <= '0;
    end else if (req && pg_ok) begin
      req_tog_q   <= ~ack_tog_q;
      pend_page_q <= bus.pg_page;
    end
  end

  // Negedge fetch and page-switch apply; leaving RUN drops any request
  always_ff @(negedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      instr_q    <= NOP_INSTR;
      page_cur_q <= '0;
      ack_tog_q  <= 1'b0;
    end else if (!run) begin
      instr_q    <= NOP_INSTR;
      page_cur_q <= '0;
      ack_tog_q  <= req_tog_q;
    end else begin
      instr_q <= rdata;
      if (apply) begin
        page_cur_q <= pend_page_q;
        ack_tog_q  <= req_tog_q;
      end
    end
  end
`else
  logic pending_q;

  assign pending    = pending_q;
  assign apply      = run && !bus.reload && pending_q && (bus.PC == '0);
  assign fetch_page = apply ? pend_page_q : page_cur_q;

  // Fetch and page switch; a request on the apply edge is only latched
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      instr_q     <= NOP_INSTR;
      page_cur_q  <= '0;
      pend_page_q <= '0;
      pending_q   <= 1'b0;
    end else if (!run || bus.reload) begin
      instr_q <= NOP_INSTR;
      if (run) begin
        page_cur_q <= '0;
        pending_q  <= 1'b0;
      end
    end else begin
      instr_q <= rdata;
      if (apply) begin
        page_cur_q <= pend_page_q;
        pending_q  <= 1'b0;
      end
      if (req && pg_ok) begin
        pend_page_q <= bus.pg_page;
        pending_q   <= 1'b1;
      end
    end
  end
`endif

  assign bus.ld_ready   = !run;
  assign bus.core_rstn  = run;
  assign bus.INSTR      = instr_q;
  assign bus.page_cur   = page_cur_q;
  assign bus.pg_pending = pending;
  assign bus.pg_err     = pg_err_q;
endmodule

// File: tb/tb_paged_pmem_fetch.sv
// tb/tb_paged_pmem_fetch.sv - directed self-checking bench for paged_pmem_fetch
`timescale 1ns/1ps
module tb_paged_pmem_fetch;
  localparam int         NP  = 7;
  localparam int         PCL = 3;
  localparam int         IL  = 8;
  localparam int         PW  = 3;
  localparam logic [7:0] NOP = 8'hEA;

  logic CLK = 1'b0;
  logic RSTN;
  int   vectors = 0;
  int   errors  = 0;

  paged_pmem_fetch_if #(.PC_LEN(PCL), .INSTR_LEN(IL), .PAGE_W(PW)) bus ();

  paged_pmem_fetch #(.PC_LEN(PCL), .INSTR_LEN(IL), .NUM_PAGES(NP), .NOP_INSTR(NOP)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input logic [2:0] pg, input logic [2:0] a, input logic [7:0] d,
                           input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_page  = pg;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic err_exp);
    vectors++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL %s ld_ready: got %b want 1", tag, bus.ld_ready); end
    vectors++; if (bus.core_rstn !== 1'b0) begin errors++; $display("FAIL %s core_rstn: got %b want 0", tag, bus.core_rstn); end
    vectors++; if (bus.INSTR !== NOP) begin errors++; $display("FAIL %s INSTR: got %h want %h", tag, bus.INSTR, NOP); end
    vectors++; if (bus.page_cur !== 3'd0) begin errors++; $display("FAIL %s page_cur: got %0d want 0", tag, bus.page_cur); end
    vectors++; if (bus.pg_pending !== 1'b0) begin errors++; $display("FAIL %s pg_pending: got %b want 0", tag, bus.pg_pending); end
    vectors++; if (bus.pg_err !== err_exp) begin errors++; $display("FAIL %s pg_err: got %b want %b", tag, bus.pg_err, err_exp); end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    bus.ld_valid = 0; bus.ld_page = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ld_last = 0;
    bus.reload = 0; bus.pg_valid = 0; bus.pg_page = 0; bus.PC = 0;
    repeat (2) tick();
    check_idle("reset_held", 1'b0);
    RSTN = 1'b1;
    tick();
    check_idle("reset_released", 1'b0);
  endtask

  task automatic test_load_run();
    load_word(3'd5, 3'd0, 8'h50, 1'b0);
    load_word(3'd5, 3'd1, 8'h51, 1'b0);
    load_word(3'd6, 3'd0, 8'h60, 1'b0);
    load_word(3'd3, 3'd0, 8'h30, 1'b0);
    load_word(3'd0, 3'd7, 8'h17, 1'b0);
    vectors++; if (bus.core_rstn !== 1'b0) begin errors++; $display("FAIL load_core_rstn: got %b want 0", bus.core_rstn); end
    load_word(3'd0, 3'd0, 8'h11, 1'b0);
    load_word(3'd0, 3'd1, 8'h12, 1'b0);
    load_word(3'd0, 3'd2, 8'h13, 1'b0);
    load_word(3'd0, 3'd3, 8'h14, 1'b1);
    vectors++; if (bus.core_rstn !== 1'b1) begin errors++; $display("FAIL run_core_rstn: got %b want 1", bus.core_rstn); end
    vectors++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL run_ld_ready: got %b want 0", bus.ld_ready); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.INSTR !== 8'h11) begin errors++; $display("FAIL run_pc0: got %h want 11", bus.INSTR); end
    bus.PC = 3'd1; tick();
    vectors++; if (bus.INSTR !== 8'h12) begin errors++; $display("FAIL run_pc1: got %h want 12", bus.INSTR); end
  endtask

  task automatic test_page_switch();
    bus.PC = 3'd7; bus.pg_valid = 1'b1; bus.pg_page = 3'd5; tick();
    bus.pg_valid = 1'b0;
    vectors++; if (bus.pg_pending !== 1'b1) begin errors++; $display("FAIL sw_pending: got %b want 1", bus.pg_pending); end
    vectors++; if (bus.page_cur !== 3'd0) begin errors++; $display("FAIL sw_page_before: got %0d want 0", bus.page_cur); end
    vectors++; if (bus.INSTR !== 8'h17) begin errors++; $display("FAIL sw_pc7: got %h want 17", bus.INSTR); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.INSTR !== 8'h50) begin errors++; $display("FAIL sw_apply_instr: got %h want 50", bus.INSTR); end
    vectors++; if (bus.page_cur !== 3'd5) begin errors++; $display("FAIL sw_apply_page: got %0d want 5", bus.page_cur); end
    vectors++; if (bus.pg_pending !== 1'b0) begin errors++; $display("FAIL sw_apply_pending: got %b want 0", bus.pg_pending); end
    bus.PC = 3'd1; tick();
    vectors++; if (bus.INSTR !== 8'h51) begin errors++; $display("FAIL sw_pc1: got %h want 51", bus.INSTR); end
  endtask

  task automatic test_last_wins();
    bus.PC = 3'd2;
    bus.pg_valid = 1'b1; bus.pg_page = 3'd3; tick();
    bus.pg_page = 3'd6; tick();
    bus.pg_valid = 1'b0;
    vectors++; if (bus.page_cur !== 3'd5) begin errors++; $display("FAIL lw_page_held: got %0d want 5", bus.page_cur); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.page_cur !== 3'd6) begin errors++; $display("FAIL lw_page: got %0d want 6", bus.page_cur); end
    vectors++; if (bus.INSTR !== 8'h60) begin errors++; $display("FAIL lw_instr: got %h want 60", bus.INSTR); end
    bus.pg_valid = 1'b1; bus.pg_page = 3'd3; tick();
    bus.pg_valid = 1'b0;
    vectors++; if (bus.page_cur !== 3'd6) begin errors++; $display("FAIL same_edge_page: got %0d want 6", bus.page_cur); end
    vectors++; if (bus.pg_pending !== 1'b1) begin errors++; $display("FAIL same_edge_pending: got %b want 1", bus.pg_pending); end
    vectors++; if (bus.INSTR !== 8'h60) begin errors++; $display("FAIL same_edge_instr: got %h want 60", bus.INSTR); end
    bus.PC = 3'd1; tick();
    vectors++; if (bus.page_cur !== 3'd6) begin errors++; $display("FAIL same_edge_pc1_page: got %0d want 6", bus.page_cur); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.page_cur !== 3'd3) begin errors++; $display("FAIL deferred_page: got %0d want 3", bus.page_cur); end
    vectors++; if (bus.INSTR !== 8'h30) begin errors++; $display("FAIL deferred_instr: got %h want 30", bus.INSTR); end
  endtask

  task automatic test_pg_err();
    vectors++; if (bus.pg_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", bus.pg_err); end
    bus.PC = 3'd3; bus.pg_valid = 1'b1; bus.pg_page = 3'd5; tick();
    bus.pg_page = 3'd7; tick();
    bus.pg_valid = 1'b0;
    vectors++; if (bus.pg_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus.pg_err); end
    vectors++; if (bus.pg_pending !== 1'b1) begin errors++; $display("FAIL err_pending_kept: got %b want 1", bus.pg_pending); end
    vectors++; if (bus.page_cur !== 3'd3) begin errors++; $display("FAIL err_page_kept: got %0d want 3", bus.page_cur); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.page_cur !== 3'd5) begin errors++; $display("FAIL err_apply_page: got %0d want 5", bus.page_cur); end
    vectors++; if (bus.INSTR !== 8'h50) begin errors++; $display("FAIL err_apply_instr: got %h want 50", bus.INSTR); end
    vectors++; if (bus.pg_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.pg_err); end
  endtask

  task automatic test_reload();
    bus.PC = 3'd2; bus.pg_valid = 1'b1; bus.pg_page = 3'd6; bus.reload = 1'b1; tick();
    bus.reload = 1'b0; bus.pg_valid = 1'b0;
    check_idle("reload", 1'b1);
    load_word(3'd0, 3'd0, 8'h21, 1'b1);
    vectors++; if (bus.core_rstn !== 1'b1) begin errors++; $display("FAIL reload_core_rstn: got %b want 1", bus.core_rstn); end
    bus.PC = 3'd0; tick();
    vectors++; if (bus.INSTR !== 8'h21) begin errors++; $display("FAIL reload_new_word: got %h want 21", bus.INSTR); end
    bus.PC = 3'd1; tick();
    vectors++; if (bus.INSTR !== 8'h12) begin errors++; $display("FAIL reload_old_word: got %h want 12", bus.INSTR); end
  endtask

  task automatic test_async_reset();
    bus.reload = 1'b1; tick();
    bus.reload = 1'b0;
    load_word(3'd1, 3'd0, 8'h41, 1'b0);
    #2 RSTN = 1'b0;
    #1;
    check_idle("async_reset", 1'b0);
    #2 RSTN = 1'b1;
    load_word(3'd7, 3'd0, 8'h99, 1'b0);
    vectors++; if (bus.pg_err !== 1'b1) begin errors++; $display("FAIL ld_err_set: got %b want 1", bus.pg_err); end
    vectors++; if (bus.core_rstn !== 1'b0) begin errors++; $display("FAIL ld_err_still_load: got %b want 0", bus.core_rstn); end
    load_word(3'd1, 3'd1, 8'h42, 1'b1);
    bus.PC = 3'd0; tick();
    vectors++; if (bus.INSTR !== 8'h21) begin errors++; $display("FAIL ar_page0: got %h want 21", bus.INSTR); end
    bus.PC = 3'd5; bus.pg_valid = 1'b1; bus.pg_page = 3'd1; tick();
    bus.pg_valid = 1'b0;
    bus.PC = 3'd0; tick();
    vectors++; if (bus.INSTR !== 8'h41) begin errors++; $display("FAIL ar_page1_w0: got %h want 41", bus.INSTR); end
    vectors++; if (bus.page_cur !== 3'd1) begin errors++; $display("FAIL ar_page1: got %0d want 1", bus.page_cur); end
    bus.PC = 3'd1; tick();
    vectors++; if (bus.INSTR !== 8'h42) begin errors++; $display("FAIL ar_page1_w1: got %h want 42", bus.INSTR); end
    vectors++; if (bus.pg_err !== 1'b1) begin errors++; $display("FAIL ar_err_sticky: got %b want 1", bus.pg_err); end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_page_switch();
    test_last_wins();
    test_pg_err();
    test_reload();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
